// File: rtl/dma64_pkg.sv
// Shared types and helpers for the 64-bit DMA memory responder.
// No logic, no latency; sizes are log2(bytes per beat), clamped to 8 bytes.
package dma64_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    localparam logic [2:0] DMA_SIZE_8B = 3'd3;
    localparam logic [2:0] DMA_SIZE_4B = 3'd2;

    function automatic logic [32:0] dma_beats(input logic [31:0] len, input logic [1:0] size);
        logic [32:0] bytes_per_beat;
        bytes_per_beat = 33'd1 << size;
        return ({1'b0, len} + bytes_per_beat - 33'd1) >> size;
    endfunction

    function automatic logic [7:0] beat_byte_en(input logic [1:0] size);
        logic [7:0] be;
        case ({1'b0, size})
            DMA_SIZE_8B: be = 8'hFF;
            DMA_SIZE_4B: be = 8'h0F;
            3'd1:        be = 8'h03;
            default:     be = 8'h01;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dma64_skid_buf.sv
// Two-entry 64-bit valid/ready FIFO holding read beats; 1 cycle push-to-valid.
// Backpressure: in_rdy low only when full; head entry is held stable while out_rdy is low.
module dma64_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [63:0] in_dat,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [63:0] out_dat,
    output logic [1:0]  count
);

    logic [63:0] head;
    logic [63:0] tail;
    logic [1:0]  cnt;
    logic        push;
    logic        pop;

    assign in_rdy  = (cnt != 2'd2);
    assign out_vld = (cnt != 2'd0);
    assign out_dat = head;
    assign count   = cnt;
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= 2'd0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push) begin
                        head <= in_dat;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= in_dat;
                    end else if (push) begin
                        tail <= in_dat;
                        cnt  <= 2'd2;
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head <= tail;
                        cnt  <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/dma64_mem_responder.sv
// DMA responder serving read/write bursts from internal memory; DMA64_RSP_STALL_EN adds LFSR stalls.
// First read beat 2 cycles after ctrl accept, then 1/cycle; read beats stall on ready, write ready is registered.
module dma64_mem_responder
    import dma64_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = 65536,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_read_ctrl_valid,
    output logic        dma_read_ctrl_ready,
    input  logic [31:0] dma_read_ctrl_data_index,
    input  logic [31:0] dma_read_ctrl_data_length,
    input  logic [2:0]  dma_read_ctrl_data_size,
    output logic        dma_read_chnl_valid,
    input  logic        dma_read_chnl_ready,
    output logic [63:0] dma_read_chnl_data,
    input  logic        dma_write_ctrl_valid,
    output logic        dma_write_ctrl_ready,
    input  logic [31:0] dma_write_ctrl_data_index,
    input  logic [31:0] dma_write_ctrl_data_length,
    input  logic [2:0]  dma_write_ctrl_data_size,
    input  logic        dma_write_chnl_valid,
    output logic        dma_write_chnl_ready,
    input  logic [63:0] dma_write_chnl_data,
    input  logic        bd_wr,
    input  logic [31:0] bd_addr,
    input  logic [63:0] bd_wdata,
    output logic [63:0] bd_rdata,
    output logic        rsp_busy,
    output logic        rsp_err,
    output logic [31:0] debug
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int WORDS = MEM_BYTES / 8;
    localparam int WW    = (AW > 3) ? AW - 3 : 1;

    state_t          state;
    state_t          state_nxt;
    logic            ctrl_rdy_q;
    logic            wr_rdy_q;
    logic            err_q;
    logic [AW-1:0]   addr_q;
    logic [1:0]      size_q;
    logic [32:0]     issue_left;
    logic [32:0]     xfer_left;
    logic [63:0]     bd_rdata_q;
    logic [63:0]     mem [WORDS];
    logic            stall;

    logic            acc_rd;
    logic            acc_wr;
    logic [31:0]     cmd_idx;
    logic [31:0]     cmd_len;
    logic [2:0]      cmd_size_raw;
    logic [1:0]      cmd_size;
    logic [32:0]     cmd_beats;

    logic [WW-1:0]   w0;
    logic [WW-1:0]   w1;
    logic [WW-1:0]   bd_w;
    logic [2:0]      off;
    logic [7:0]      be8;
    logic [15:0]     be16;
    logic [127:0]    rd_win;
    logic [63:0]     rd_dat;
    logic [127:0]    wr_win;

    logic            rd_issue;
    logic            rd_hs;
    logic            wr_hs;
    logic            bd_we_ok;
    logic            buf_in_rdy;
    logic            buf_out_vld;
    logic [63:0]     buf_out_dat;
    logic [1:0]      buf_count;
    logic            unused_bits;

`ifdef DMA64_RSP_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= STALL_SEED;
        else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign stall = lfsr[0];
`else
    logic unused_seed;
    assign unused_seed = ^STALL_SEED;
    assign stall       = 1'b0;
`endif

    // Read wins arbitration, so the write is only taken when no read is offered.
    assign acc_rd       = (state == S_IDLE) && ctrl_rdy_q && dma_read_ctrl_valid;
    assign acc_wr       = (state == S_IDLE) && ctrl_rdy_q && dma_write_ctrl_valid && !dma_read_ctrl_valid;
    assign cmd_idx      = dma_read_ctrl_valid ? dma_read_ctrl_data_index  : dma_write_ctrl_data_index;
    assign cmd_len      = dma_read_ctrl_valid ? dma_read_ctrl_data_length : dma_write_ctrl_data_length;
    assign cmd_size_raw = dma_read_ctrl_valid ? dma_read_ctrl_data_size   : dma_write_ctrl_data_size;
    assign cmd_size     = (cmd_size_raw > DMA_SIZE_8B) ? 2'd3 : cmd_size_raw[1:0];
    assign cmd_beats    = dma_beats(cmd_len, cmd_size);
    assign unused_bits  = ^{cmd_idx, bd_addr};

    assign off    = addr_q[2:0];
    assign w0     = WW'(addr_q >> 3) & WW'(WORDS - 1);
    assign w1     = (w0 + WW'(1)) & WW'(WORDS - 1);
    assign bd_w   = WW'(bd_addr) & WW'(WORDS - 1);
    assign be8    = beat_byte_en(size_q);
    assign be16   = {8'h00, be8} << off;
    assign rd_win = {mem[w1], mem[w0]} >> {off, 3'b000};
    assign wr_win = {64'd0, dma_write_chnl_data} << {off, 3'b000};

    always_comb begin
        rd_dat = '0;
        for (int b = 0; b < 8; b++) begin
            if (be8[b]) rd_dat[8*b +: 8] = rd_win[8*b +: 8];
        end
    end

    // Memory reads are combinational into the buffer, so nothing is ever in
    // flight and the occupancy limit reduces to the buffer having room.
    assign rd_issue = (state == S_RD) && (issue_left != '0) && buf_in_rdy && !stall;
    assign rd_hs    = buf_out_vld && dma_read_chnl_ready;
    assign wr_hs    = dma_write_chnl_valid && dma_write_chnl_ready;
    assign bd_we_ok = bd_wr && !(wr_hs && ((bd_w == w0) || ((|be16[15:8]) && (bd_w == w1))));

    dma64_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (rd_issue),
        .in_rdy  (buf_in_rdy),
        .in_dat  (rd_dat),
        .out_vld (buf_out_vld),
        .out_rdy (dma_read_chnl_ready),
        .out_dat (buf_out_dat),
        .count   (buf_count)
    );

    always_ff @(posedge clk) begin
        if (bd_we_ok) mem[bd_w] <= bd_wdata;
        if (wr_hs) begin
            for (int b = 0; b < 8; b++) begin
                if (be16[b])     mem[w0][8*b +: 8] <= wr_win[8*b +: 8];
                if (be16[8 + b]) mem[w1][8*b +: 8] <= wr_win[64 + 8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (acc_rd)      state_nxt = S_RD;
                else if (acc_wr) state_nxt = S_WR;
            end
            S_RD: begin
                if ((xfer_left == '0) || ((xfer_left == 33'd1) && rd_hs)) state_nxt = S_IDLE;
            end
            S_WR: begin
                if ((xfer_left == '0) || ((xfer_left == 33'd1) && wr_hs)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_rdy_q <= 1'b0;
            wr_rdy_q   <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            size_q     <= 2'd0;
            issue_left <= '0;
            xfer_left  <= '0;
            bd_rdata_q <= '0;
        end else begin
            ctrl_rdy_q <= (state_nxt == S_IDLE);
            bd_rdata_q <= mem[bd_w];
            if (acc_rd || acc_wr) begin
                addr_q     <= cmd_idx[AW-1:0];
                size_q     <= cmd_size;
                issue_left <= cmd_beats;
                xfer_left  <= cmd_beats;
                wr_rdy_q   <= acc_wr && (cmd_beats != '0);
                if (cmd_size_raw > DMA_SIZE_8B) err_q <= 1'b1;
            end else begin
                if (rd_issue || wr_hs) addr_q <= addr_q + (AW'(1) << size_q);
                if (rd_issue)          issue_left <= issue_left - 33'd1;
                if (rd_hs || wr_hs)    xfer_left <= xfer_left - 33'd1;
                if (wr_hs && (xfer_left == 33'd1)) wr_rdy_q <= 1'b0;
            end
        end
    end

    assign dma_read_ctrl_ready  = ctrl_rdy_q;
    assign dma_write_ctrl_ready = ctrl_rdy_q;
    assign dma_read_chnl_valid  = buf_out_vld;
    assign dma_read_chnl_data   = buf_out_dat;
    assign dma_write_chnl_ready = wr_rdy_q && !stall;
    assign bd_rdata             = bd_rdata_q;
    assign rsp_busy             = (state != S_IDLE);
    assign rsp_err              = err_q;
    assign debug                = {27'd0, state, 1'b0, buf_count};

endmodule

// File: tb/tb_dma64_mem_responder.sv
// Scoreboard bench for dma64_mem_responder: directed commands, expected read beats queued, monitor compares.
module tb_dma64_mem_responder;

    localparam int MB = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dma_read_ctrl_valid = 1'b0;
    logic        dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index = '0;
    logic [31:0] dma_read_ctrl_data_length = '0;
    logic [2:0]  dma_read_ctrl_data_size = '0;
    logic        dma_read_chnl_valid;
    logic        dma_read_chnl_ready = 1'b1;
    logic [63:0] dma_read_chnl_data;
    logic        dma_write_ctrl_valid = 1'b0;
    logic        dma_write_ctrl_ready;
    logic [31:0] dma_write_ctrl_data_index = '0;
    logic [31:0] dma_write_ctrl_data_length = '0;
    logic [2:0]  dma_write_ctrl_data_size = '0;
    logic        dma_write_chnl_valid = 1'b0;
    logic        dma_write_chnl_ready;
    logic [63:0] dma_write_chnl_data = '0;
    logic        bd_wr = 1'b0;
    logic [31:0] bd_addr = '0;
    logic [63:0] bd_wdata = '0;
    logic [63:0] bd_rdata;
    logic        rsp_busy;
    logic        rsp_err;
    logic [31:0] debug;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int last_hs_cyc = 0;
    logic [63:0] exp_q[$];
    logic [63:0] wdat_q[$];

    dma64_mem_responder #(.MEM_BYTES(MB), .STALL_SEED(16'hACE1)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .dma_read_ctrl_valid        (dma_read_ctrl_valid),
        .dma_read_ctrl_ready        (dma_read_ctrl_ready),
        .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
        .dma_read_chnl_valid        (dma_read_chnl_valid),
        .dma_read_chnl_ready        (dma_read_chnl_ready),
        .dma_read_chnl_data         (dma_read_chnl_data),
        .dma_write_ctrl_valid       (dma_write_ctrl_valid),
        .dma_write_ctrl_ready       (dma_write_ctrl_ready),
        .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
        .dma_write_chnl_valid       (dma_write_chnl_valid),
        .dma_write_chnl_ready       (dma_write_chnl_ready),
        .dma_write_chnl_data        (dma_write_chnl_data),
        .bd_wr                      (bd_wr),
        .bd_addr                    (bd_addr),
        .bd_wdata                   (bd_wdata),
        .bd_rdata                   (bd_rdata),
        .rsp_busy                   (rsp_busy),
        .rsp_err                    (rsp_err),
        .debug                      (debug)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Every valid read beat must equal the head of the expected queue, stalled or not.
    always @(negedge clk) begin
        if (rst && dma_read_chnl_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected got=%h exp=none", dma_read_chnl_data);
            end else begin
                check("rd_beat", dma_read_chnl_data, exp_q[0]);
                if (dma_read_chnl_ready) begin
                    void'(exp_q.pop_front());
                    hs_cnt++;
                    last_hs_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input int w, input logic [63:0] d);
        bd_wr = 1'b1; bd_addr = w; bd_wdata = d;
        tick();
        bd_wr = 1'b0;
    endtask

    task automatic bd_check(input string name, input int w, input logic [63:0] exp);
        bd_addr = w;
        tick();
        @(negedge clk);
        check(name, bd_rdata, exp);
        tick();
    endtask

    task automatic issue(input bit rd, input logic [31:0] idx, input logic [31:0] len,
                         input logic [2:0] sz, output int acc_cyc);
        if (rd) begin
            dma_read_ctrl_data_index = idx; dma_read_ctrl_data_length = len;
            dma_read_ctrl_data_size = sz; dma_read_ctrl_valid = 1'b1;
        end else begin
            dma_write_ctrl_data_index = idx; dma_write_ctrl_data_length = len;
            dma_write_ctrl_data_size = sz; dma_write_ctrl_valid = 1'b1;
        end
        acc_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rd ? dma_read_ctrl_ready : dma_write_ctrl_ready) begin
                acc_cyc = cyc;
                break;
            end
        end
        if (acc_cyc < 0) begin
            total++; bad++;
            $display("FAIL ctrl_accept_timeout got=none exp=accept");
        end
        tick();
        if (rd) dma_read_ctrl_valid = 1'b0;
        else    dma_write_ctrl_valid = 1'b0;
    endtask

    task automatic send_wbeats();
        bit ok;
        while (wdat_q.size() != 0) begin
            dma_write_chnl_valid = 1'b1;
            dma_write_chnl_data  = wdat_q[0];
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (dma_write_chnl_ready) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                total++; bad++;
                $display("FAIL wr_beat_timeout got=ready_low exp=ready_high");
                wdat_q.delete();
            end else begin
                void'(wdat_q.pop_front());
            end
            tick();
        end
        dma_write_chnl_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!rsp_busy) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s busy_stuck got=1 exp=0", name);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int acc;
        int wacc;
        int base;
        bit seen;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rd_ctrl_rdy", {63'd0, dma_read_ctrl_ready}, 64'd0);
        check("rst_wr_ctrl_rdy", {63'd0, dma_write_ctrl_ready}, 64'd0);
        check("rst_rd_vld", {63'd0, dma_read_chnl_valid}, 64'd0);
        check("rst_wr_rdy", {63'd0, dma_write_chnl_ready}, 64'd0);
        check("rst_busy", {63'd0, rsp_busy}, 64'd0);
        check("rst_err", {63'd0, rsp_err}, 64'd0);
        check("rst_debug", {32'd0, debug}, 64'd0);
        check("rst_bd_rdata", bd_rdata, 64'd0);
        #1 rst = 1'b1;
        #1 check("ctrl_rdy_at_release", {63'd0, dma_read_ctrl_ready}, 64'd0);
        @(negedge clk);
        check("ctrl_rdy_after_release", {63'd0, dma_read_ctrl_ready}, 64'd1);
        tick();

        // Aligned 4-beat read, ready held high
        for (int w = 0; w < 4; w++) begin
            bd_write(w, 64'(w));
            exp_q.push_back(64'(w));
        end
        issue(1'b1, 32'h0, 32'd32, 3'd3, acc);
        @(negedge clk);
        check("lat_a1_no_vld", {63'd0, dma_read_chnl_valid}, 64'd0);
        @(negedge clk);
        check("lat_a2_vld", {63'd0, dma_read_chnl_valid}, 64'd1);
        repeat (4) @(negedge clk);
        check("aligned_busy_fall", {63'd0, rsp_busy}, 64'd0);
        check("aligned_ctrl_rdy", {63'd0, dma_read_ctrl_ready}, 64'd1);
        check("aligned_last_hs_cyc", 64'(last_hs_cyc), 64'(acc + 5));
        check("aligned_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // Packed 4-byte writes, upper beat bits must be ignored
        bd_write(32'h800, 64'hFFFF_FFFF_FFFF_FFFF);
        bd_write(32'h801, 64'hFFFF_FFFF_FFFF_FFFF);
        wdat_q = '{64'hDEAD_BEEF_0000_000A, 64'h1234_5678_0000_000B,
                   64'hFFFF_FFFF_0000_000C, 64'h5555_AAAA_0000_000D};
        issue(1'b0, 32'h4000, 32'd16, 3'd2, acc);
        send_wbeats();
        @(negedge clk);
        check("wr_rdy_drop", {63'd0, dma_write_chnl_ready}, 64'd0);
        wait_idle("packed_write");
        bd_check("packed_w800", 32'h800, 64'h0000_000B_0000_000A);
        bd_check("packed_w801", 32'h801, 64'h0000_000D_0000_000C);

        // Single byte write into lane 3, neighbours untouched
        bd_write(32'h802, 64'h1111_1111_1111_1111);
        wdat_q = '{64'hFFFF_FFFF_FFFF_FF5A};
        issue(1'b0, 32'h4013, 32'd1, 3'd0, acc);
        send_wbeats();
        wait_idle("byte_write");
        bd_check("byte_lane3", 32'h802, 64'h1111_1111_5A11_1111);

        // Unaligned 4-byte read crossing a word boundary
        exp_q.push_back(64'h0000_0000_000C_0000);
        issue(1'b1, 32'h4006, 32'd4, 3'd2, acc);
        wait_idle("unaligned_read");
        check("unaligned_drained", 64'(exp_q.size()), 64'd0);

        // 8-beat read with ready toggling every cycle
        for (int i = 0; i < 8; i++) begin
            bd_write(32'h10 + i, 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h1_0001);
            exp_q.push_back(64'hC0DE_0000_0000_0000 + 64'(i) * 64'h1_0001);
        end
        base = hs_cnt;
        issue(1'b1, 32'h80, 32'd64, 3'd3, acc);
        for (int i = 0; i < 200 && (hs_cnt - base) < 8; i++) begin
            dma_read_chnl_ready = ~dma_read_chnl_ready;
            tick();
        end
        dma_read_chnl_ready = 1'b1;
        wait_idle("backpressure");
        check("bp_handshakes", 64'(hs_cnt - base), 64'd8);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Simultaneous commands: read first, write 1 cycle after last read beat
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd1);
        dma_read_ctrl_data_index = 32'h0; dma_read_ctrl_data_length = 32'd16;
        dma_read_ctrl_data_size = 3'd3;
        dma_write_ctrl_data_index = 32'h100; dma_write_ctrl_data_length = 32'd8;
        dma_write_ctrl_data_size = 3'd3;
        dma_read_ctrl_valid = 1'b1;
        dma_write_ctrl_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = dma_read_ctrl_ready;
        end
        tick();
        dma_read_ctrl_valid = 1'b0;
        wacc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dma_write_ctrl_ready) begin wacc = cyc; break; end
        end
        check("simul_rd_done_first", 64'(exp_q.size()), 64'd0);
        check("simul_wr_accept_cyc", 64'(wacc), 64'(last_hs_cyc + 1));
        tick();
        dma_write_ctrl_valid = 1'b0;
        wdat_q = '{64'h0123_4567_89AB_CDEF};
        send_wbeats();
        wait_idle("simul_write");
        bd_check("simul_w20", 32'h20, 64'h0123_4567_89AB_CDEF);

        // Zero-length read
        base = hs_cnt;
        issue(1'b1, 32'h0, 32'd0, 3'd3, acc);
        repeat (2) @(negedge clk);
        check("zero_len_idle", {63'd0, rsp_busy}, 64'd0);
        check("zero_len_ctrl_rdy", {63'd0, dma_read_ctrl_ready}, 64'd1);
        check("zero_len_no_beats", 64'(hs_cnt - base), 64'd0);
        tick();

        // Size 5 clamps to 8-byte beats and sets the sticky error
        check("err_before_size5", {63'd0, rsp_err}, 64'd0);
        bd_write(4, 64'h0123_4567_89AB_CDEF);
        exp_q.push_back(64'h0123_4567_89AB_CDEF);
        issue(1'b1, 32'h20, 32'd8, 3'd5, acc);
        wait_idle("size5_read");
        check("size5_err", {63'd0, rsp_err}, 64'd1);
        check("size5_drained", 64'(exp_q.size()), 64'd0);

        // Burst wraps from the top word to word 0
        bd_write(MB / 8 - 1, 64'hFEED_FACE_CAFE_BEEF);
        bd_write(0, 64'hA5A5_5A5A_0F0F_F0F0);
        exp_q.push_back(64'hFEED_FACE_CAFE_BEEF);
        exp_q.push_back(64'hA5A5_5A5A_0F0F_F0F0);
        issue(1'b1, MB - 8, 32'd16, 3'd3, acc);
        wait_idle("wrap_read");
        check("wrap_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of an 8-beat read
        for (int i = 0; i < 8; i++) begin
            bd_write(32'h40 + i, 64'h7700_0000_0000_0000 + 64'(i));
            exp_q.push_back(64'h7700_0000_0000_0000 + 64'(i));
        end
        base = hs_cnt;
        issue(1'b1, 32'h200, 32'd64, 3'd3, acc);
        for (int i = 0; i < 50 && (hs_cnt - base) < 2; i++) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_rd_vld", {63'd0, dma_read_chnl_valid}, 64'd0);
        check("mid_rst_ctrl_rdy", {63'd0, dma_read_ctrl_ready}, 64'd0);
        check("mid_rst_busy", {63'd0, rsp_busy}, 64'd0);
        check("mid_rst_err", {63'd0, rsp_err}, 64'd0);
        check("mid_rst_debug", {32'd0, debug}, 64'd0);
        check("mid_rst_rd_data", dma_read_chnl_data, 64'd0);
        check("mid_rst_bd_rdata", bd_rdata, 64'd0);
        exp_q.delete();
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("mid_rst_release_rdy", {63'd0, dma_read_ctrl_ready}, 64'd0);
        @(negedge clk);
        check("mid_rst_rdy_rise", {63'd0, dma_write_ctrl_ready}, 64'd1);
        tick();
        bd_check("mem_intact_40", 32'h40, 64'h7700_0000_0000_0000);
        bd_check("mem_intact_47", 32'h47, 64'h7700_0000_0000_0007);
        bd_check("mem_intact_800", 32'h800, 64'h0000_000B_0000_000A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma64_mem_responder.md
# dma64_mem_responder

System-side responder for the 64-bit accelerator DMA interface. Accepts read and write commands from an accelerator wrapper, serves them from an internal byte-addressed memory, and streams beats over the read and write data channels with valid/ready flow control. Used as the memory/DMA model in block-level benches and as the on-chip scratch responder in standalone accelerator tiles; a backdoor port preloads and inspects memory.

## Interface
- `MEM_BYTES`, 65536: memory size in bytes; power of two, at least 8; the array holds `MEM_BYTES/8` 64-bit words.
- `STALL_SEED`, 16'hACE1: LFSR seed, used only with `DMA64_RSP_STALL_EN`.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `dma_read_ctrl_valid` in 1, `dma_read_ctrl_ready` out 1: read command handshake.
- `dma_read_ctrl_data_index` in 32: start byte address.
- `dma_read_ctrl_data_length` in 32: length in bytes.
- `dma_read_ctrl_data_size` in 3: log2 of bytes per beat.
- `dma_read_chnl_valid` out 1, `dma_read_chnl_ready` in 1, `dma_read_chnl_data` out 64: read beats.
- `dma_write_ctrl_valid` in 1, `dma_write_ctrl_ready` out 1, `dma_write_ctrl_data_index` in 32, `dma_write_ctrl_data_length` in 32, `dma_write_ctrl_data_size` in 3: write command, same encoding as the read command.
- `dma_write_chnl_valid` in 1, `dma_write_chnl_ready` out 1, `dma_write_chnl_data` in 64: write beats.
- `bd_wr` in 1, `bd_addr` in 32, `bd_wdata` in 64, `bd_rdata` out 64: backdoor. `bd_addr` is a word index taken modulo `MEM_BYTES/8`.
- `rsp_busy` out 1: high whenever the state is not S_IDLE.
- `rsp_err` out 1: sticky; set when a command arrives with size > 3.
- `debug` out 32: `{27'd0, state[1:0], rd_buf_count[2:0]}`.

## Operation
- States:
  - S_IDLE: both ctrl_ready outputs are high.
  - S_RD: reading.
  - S_WR: writing.
- Command acceptance:
  - In S_IDLE, the read command wins if both ctrl_valid inputs are high.
  - On accept, both ctrl_ready outputs drop in the next cycle.
  - The block latches address, size and beat count.
- Beat count: `(length + 2^size − 1) >> size`, computed in 33 bits.
- Size > 3: the size is clamped to 3 and `rsp_err` is set. `rsp_err` clears only on reset.
- Zero-length command: accepted, no beats move, and the block returns to S_IDLE on the next cycle.
- Address arithmetic:
  - The address increments by 2^size per beat.
  - All addresses are taken modulo `MEM_BYTES`.
  - A burst wraps past the top of memory to 0.
- Read beat layout:
  - The `2^size` bytes starting at the current address, shifted to bit 0, zero-extended to 64 bits, little-endian.
  - An unaligned beat that crosses a 64-bit word boundary reads the next word.
- Write beat: `dma_write_chnl_data[8·2^size−1:0]` is written to `2^size` bytes at the current address, with the same layout. Other bytes are untouched.
- Read path:
  - The memory reads into sub-module `dma64_skid_buf`, a 2-entry FIFO.
  - Issue a memory read only when the entries in flight plus the entries stored total fewer than 2, and beats remain to be issued.
  - S_RD ends when the last beat completes its handshake.
- Write path: S_WR ends when the last beat is accepted.
- Backdoor: a `bd_wr` write in the same cycle as a DMA write to the same word is dropped; the DMA write wins.

## Timing
- Reset values:
  - All outputs are 0, including ctrl_ready, `bd_rdata` and `debug`.
  - ctrl_ready rises one cycle after reset deasserts.
  - Memory contents are not reset.
- Reset mid-burst: the burst is abandoned, all valid and ready outputs go low asynchronously, and the buffer empties.
- Read latency: the first read beat is valid 2 cycles after the ctrl handshake cycle.
- Read throughput: 1 beat per cycle while `dma_read_chnl_ready` is held high.
- Read data stability: `dma_read_chnl_data` is held stable while valid is high and ready is low.
- Write ready: `dma_write_chnl_ready` is high from the cycle after ctrl accept until the last beat is accepted. It is registered low in the cycle after that.
- Back-to-back commands: ctrl_ready returns high 1 cycle after a burst ends.
- Backdoor read: `bd_rdata` is valid 1 cycle after `bd_addr`.

## Configuration
- `DMA64_RSP_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with `STALL_SEED`, advances every cycle.
  - When LFSR[0] is 1, memory read issue and `dma_write_chnl_ready` are suppressed for that cycle.
  - Already-valid read beats are never withdrawn.
- `DMA64_RSP_STALL_EN` undefined: the LFSR is absent and throughput is full.

## Structure
- Package `dma64_pkg`:
  - State enum.
  - Size encodings: `DMA_SIZE_8B`=3, `DMA_SIZE_4B`=2.
  - Beat-count function.
- Sub-module `dma64_skid_buf`: 2-entry, 64-bit valid/ready FIFO with a count output.

## Test plan
- Aligned read: backdoor-load words 0..3 with `64'h0..03`, then read index 0, length 32, size 3 with ready held high. Required response: 4 consecutive beats `0,1,2,3`, the first valid 2 cycles after accept, then `rsp_busy` falls.
- Packed write: write index 0x4000, length 16, size 2, beats `32'hA`, `32'hB`, `32'hC`, `32'hD`. Required response: backdoor word 0x800 = `64'h0000000B_0000000A`; the upper 32 bits of the beat data are ignored.
- Backpressure: an 8-beat read with `dma_read_chnl_ready` toggling every cycle. Required response: data is stable while stalled, there is no loss or duplication, and exactly 8 handshakes occur.
- Simultaneous commands: read and write ctrl_valid rise in the same cycle. Required response: the read is served first, and the write is accepted 1 cycle after the read's last beat.
- Edge cases, three separate checks:
  - Length 0 → return to S_IDLE with no beats.
  - Size 5 → `rsp_err`=1 and 8-byte beats.
  - Read at index `MEM_BYTES−8`, length 16 → beats from word `MEM_BYTES/8−1`, then word 0.
- Reset mid-read: `rst` pulses low after 2 of 8 beats. Required response: all outputs are 0 immediately, ctrl_ready rises 1 cycle after release, and memory is intact.
